// File: rtl/watch_disp_pkg.sv
// Shared types and constants for the watch display datapath.
// Optional BLINK_EN build adds per-digit blanking in disp_src_sel.
package watch_disp_pkg;

  localparam int         DEF_DATA_W  = 24;
  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  typedef enum logic {
    HOME   = 1'b0,
    BROWSE = 1'b1
  } disp_state_e;

endpackage

// File: rtl/disp_src_sel_if.sv
// Bus between the display-source selector and its users (inputs, channel words, selected word).
// With BLINK_EN defined the bus also carries blink_tick and blink_mask.
interface disp_src_sel_if
  import watch_disp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
);
  logic                     tick_1hz;
  logic                     step;
  logic                     sel_load;
  logic [CH_W-1:0]          sel_idx;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          cur_ch;
  logic                     timeout;
`ifdef BLINK_EN
  logic                     blink_tick;
  logic [DATA_W/4-1:0]      blink_mask;

  modport master (
    output tick_1hz, step, sel_load, sel_idx, ch_data, blink_tick, blink_mask,
    input  out_data, cur_ch, timeout
  );
  modport slave (
    input  tick_1hz, step, sel_load, sel_idx, ch_data, blink_tick, blink_mask,
    output out_data, cur_ch, timeout
  );
`else
  modport master (
    output tick_1hz, step, sel_load, sel_idx, ch_data,
    input  out_data, cur_ch, timeout
  );
  modport slave (
    input  tick_1hz, step, sel_load, sel_idx, ch_data,
    output out_data, cur_ch, timeout
  );
`endif
endinterface

// File: rtl/disp_timeout_cnt.sv
// Inactivity counter: counts ticks while enabled, flags expiry on the TIMEOUT-th tick.
// TIMEOUT == 0 removes the counter and o_expire stays low.
module disp_timeout_cnt #(
  parameter int TIMEOUT = 10,
  parameter int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_tick,
  input  logic i_en,
  output logic o_expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign o_expire = 1'b0;
      wire w_unused = &{1'b0, clk, rst, i_clr, i_tick, i_en};
    end else begin : g_on
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

      logic [CNT_W-1:0] r_cnt;
      logic             w_hit;

      assign w_hit    = i_tick && i_en && (r_cnt == LAST);
      assign o_expire = w_hit;

      // NOTE: reset is sampled on the clock edge, and all state uses <= so every register sees pre-edge values.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (i_clr || !i_en || w_hit) begin
          r_cnt <= '0;
        end else if (i_tick) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/disp_src_sel.sv
// Registered N-channel display-source selector with step/load control and auto-return to channel 0.
// Define BLINK_EN to add the blink phase register and per-digit blanking.
module disp_src_sel
  import watch_disp_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 10
) (
  input logic           clk,
  input logic           rst,
  disp_src_sel_if.slave bus
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [CH_W-1:0]   r_cur_ch;
  logic [DATA_W-1:0] r_out_data;
  logic              r_timeout;

  disp_state_e       w_state;
  logic              w_load_valid;
  logic              w_do_step;
  logic              w_do_tick;
  logic              w_expire;
  logic [CH_W-1:0]   w_next_ch;
  logic [DATA_W-1:0] w_sel;
  logic [DATA_W-1:0] w_out_next;

  assign w_state = (r_cur_ch == '0) ? HOME : BROWSE;

  // Any sel_load pulse, valid or not, owns the cycle: step and tick are dropped.
  assign w_load_valid = bus.sel_load && (int'(bus.sel_idx) < NUM_CH);
  assign w_do_step    = bus.step && !bus.sel_load;
  assign w_do_tick    = bus.tick_1hz && !bus.sel_load && !bus.step;
  assign w_next_ch    = (r_cur_ch == CH_W'(NUM_CH - 1)) ? '0 : r_cur_ch + 1'b1;

  disp_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_load_valid || w_do_step),
    .i_tick   (w_do_tick),
    .i_en     (w_state == BROWSE),
    .o_expire (w_expire)
  );

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_cur_ch == CH_W'(k)) w_sel = bus.ch_data[k*DATA_W +: DATA_W];
    end
  end

`ifdef BLINK_EN
  logic r_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= 1'b1;
    end else if (w_load_valid || w_do_step) begin
      r_phase <= 1'b1;
    end else if (bus.blink_tick) begin
      r_phase <= ~r_phase;
    end
  end

  // Blanking sits in front of the output register, so it costs no latency.
  always_comb begin
    w_out_next = w_sel;
    if (!r_phase) begin
      for (int d = 0; d < DATA_W/4; d++) begin
        if (bus.blink_mask[d]) w_out_next[d*4 +: 4] = BLANK_DIGIT;
      end
    end
  end
`else
  assign w_out_next = w_sel;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_ch   <= '0;
      r_out_data <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout  <= w_expire;
      r_out_data <= w_out_next;
      if (w_load_valid) begin
        r_cur_ch <= bus.sel_idx;
      end else if (w_do_step) begin
        r_cur_ch <= w_next_ch;
      end else if (w_expire) begin
        r_cur_ch <= '0;
      end
    end
  end

  assign bus.cur_ch   = r_cur_ch;
  assign bus.out_data = r_out_data;
  assign bus.timeout  = r_timeout;

endmodule
